// File: rtl/sync_fifo_if.sv
// sync_fifo_if: handshake and status bundle for sync_fifo.
//   master : producer/consumer side (drives flush, wr_*, rd_en, clr_err)
//   slave  : FIFO side (drives rd_data, rd_valid, status flags, count, error flags)
interface sync_fifo_if #(
    parameter int unsigned DATA_W     = 4,
    parameter int unsigned DEPTH_LOG2 = 2
);
    logic                  flush;
    logic                  wr_en;
    logic [DATA_W-1:0]     wr_data;
    logic                  rd_en;
    logic [DATA_W-1:0]     rd_data;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow;
    logic                  underflow;
    logic                  clr_err;

    modport master (
        output flush, wr_en, wr_data, rd_en, clr_err,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty, count,
               overflow, underflow
    );

    modport slave (
        input  flush, wr_en, wr_data, rd_en, clr_err,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty, count,
               overflow, underflow
    );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data, threshold flags,
// synchronous flush and sticky overflow/underflow flags.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : sync_fifo_if slave modport (write/read handshake, status, errors)
module sync_fifo #(
    parameter int unsigned DATA_W        = 4,
    parameter int unsigned DEPTH_LOG2    = 2,
    parameter int unsigned AFULL_THRESH  = (2 ** DEPTH_LOG2) - 1,
    parameter int unsigned AEMPTY_THRESH = 1
) (
    input logic          clk,
    input logic          rst,
    sync_fifo_if.slave   bus
);
    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    localparam logic [CW-1:0] DepthC  = CW'(DEPTH);
    localparam logic [CW-1:0] AfullC  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AemptyC = CW'(AEMPTY_THRESH);

    // Storage is never reset; pointers and count alone define validity.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_W-1:0]     rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic full, empty;
    logic wr_acc, rd_acc;

    assign full   = (count_q == DepthC);
    assign empty  = (count_q == '0);
    assign wr_acc = bus.wr_en && !full && !bus.flush;
    assign rd_acc = bus.rd_en && !empty && !bus.flush;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = rd_acc;

        // Set wins over clear when both happen on the same edge.
        overflow_d  = (overflow_q && !bus.clr_err) || (bus.wr_en && full && !bus.flush);
        underflow_d = (underflow_q && !bus.clr_err) || (bus.rd_en && empty && !bus.flush);

        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
            end
            if (rd_acc) begin
                rd_ptr_d  = rd_ptr_q + DEPTH_LOG2'(1);
                rd_data_d = mem[rd_ptr_q];
            end
            unique case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= bus.wr_data;
        end
    end

    assign bus.rd_data      = rd_data_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.count        = count_q;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= AfullC);
    assign bus.almost_empty = (count_q <= AemptyC);
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule
